// File: rtl/r22sdf_pkg.sv
// Shared definitions for the R2^2 SDF FFT frame controller.
package r22sdf_pkg;

  localparam int FFT_LEN  = 64;
  localparam int LOG2_LEN = 6;
  localparam int PIPE_LAT = 63;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_RUN      = 2'd2,
    ST_FLUSH    = 2'd3
  } frame_state_t;

endpackage

// File: rtl/r22sdf_tag_dly.sv
// Valid/sop tag delay line that tracks samples through the FFT datapath.
// It shifts only when the datapath advances, so tags stay aligned with data.
// Requires depth >= 2.
module r22sdf_tag_dly
  import r22sdf_pkg::*;
#(
  parameter int depth = PIPE_LAT
) (
  input  logic sys_clk,
  input  logic sys_nrst,
  input  logic en,
  input  logic vld,
  input  logic sop,
  output logic q_vld,
  output logic q_sop,
  output logic any_vld
);

  logic [depth-1:0] vld_r;
  logic [depth-1:0] sop_r;

  // Shift the tags one stage per enabled datapath cycle; an untagged slot never carries sop.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      vld_r <= {depth{1'b0}};
      sop_r <= {depth{1'b0}};
    end else if (en) begin
      vld_r <= {vld_r[depth-2:0], vld};
      sop_r <= {sop_r[depth-2:0], sop & vld};
    end
  end

  assign q_vld   = vld_r[depth-1];
  assign q_sop   = sop_r[depth-1];
  assign any_vld = |vld_r;

endmodule

// File: rtl/r22sdf_frame_ctrl.sv
// Frame controller for an R2^2 SDF FFT: admits input frames, feeds zeros to
// drain the pipeline, and tags the bit-reversed output stream.
module r22sdf_frame_ctrl
  import r22sdf_pkg::*;
#(
  parameter int fft_length = FFT_LEN,
  parameter int pipe_lat   = PIPE_LAT
) (
  input  logic                          sys_clk,
  input  logic                          sys_nrst,
  input  logic                          sys_en,
  input  logic                          cordic_rdy,
  input  logic                          in_valid,
  input  logic                          in_sop,
  output logic                          in_ready,
  output logic                          fft_en,
  output logic                          zero_in,
  output logic                          out_valid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [$clog2(fft_length)-1:0] out_idx,
  output logic                          busy,
  output logic                          sop_err
);

  localparam int            LW      = $clog2(fft_length);
  localparam logic [LW-1:0] CNT_MAX = LW'(fft_length - 1);

  frame_state_t  state_r;
  logic [LW-1:0] in_cnt_r;
  logic [LW-1:0] out_cnt_r;
  logic [LW-1:0] rev_s;
  logic          sop_err_r;
  logic          go_s;
  logic          take_s;
  logic          tag_sop_s;
  logic          any_vld_s;

  // Handshake and datapath controls for the current cycle, decoded from state and inputs.
  always_comb begin
    go_s      = sys_en & cordic_rdy;
    in_ready  = 1'b0;
    fft_en    = 1'b0;
    zero_in   = 1'b0;
    take_s    = 1'b0;
    tag_sop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b0;
      end
      ST_WAIT_SOP: begin
        in_ready = go_s;
        if (go_s & in_valid & in_sop) begin
          fft_en    = 1'b1;
          take_s    = 1'b1;
          tag_sop_s = 1'b1;
        end else begin
          fft_en    = 1'b0;
        end
      end
      ST_RUN: begin
        in_ready = go_s;
        if (go_s & in_valid) begin
          fft_en    = 1'b1;
          take_s    = 1'b1;
          tag_sop_s = in_sop;
        end else begin
          fft_en    = 1'b0;
        end
      end
      ST_FLUSH: begin
        in_ready = go_s;
        fft_en   = go_s;
        if (in_valid & in_sop) begin
          zero_in   = 1'b0;
          take_s    = go_s;
          tag_sop_s = 1'b1;
        end else begin
          zero_in   = 1'b1;
        end
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Frame sequencing FSM with input sample counter and registered sop error pulse.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_r   <= ST_IDLE;
      in_cnt_r  <= {LW{1'b0}};
      sop_err_r <= 1'b0;
    end else begin
      sop_err_r <= take_s & in_sop & (state_r == ST_RUN) & (in_cnt_r != {LW{1'b0}});
      if (go_s) begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_WAIT_SOP;
          end
          ST_WAIT_SOP: begin
            if (take_s) begin
              in_cnt_r <= LW'(1);
              state_r  <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (take_s) begin
              if (in_sop) begin
                in_cnt_r <= LW'(1);
              end else if (in_cnt_r == CNT_MAX) begin
                in_cnt_r <= {LW{1'b0}};
                state_r  <= ST_FLUSH;
              end else begin
                in_cnt_r <= in_cnt_r + LW'(1);
              end
            end
          end
          ST_FLUSH: begin
            if (take_s) begin
              in_cnt_r <= LW'(1);
              state_r  <= ST_RUN;
            end else if (!any_vld_s) begin
              state_r  <= ST_WAIT_SOP;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  r22sdf_tag_dly #(
    .depth(pipe_lat)
  ) u_tag_dly (
    .sys_clk (sys_clk),
    .sys_nrst(sys_nrst),
    .en      (fft_en),
    .vld     (take_s),
    .sop     (tag_sop_s),
    .q_vld   (out_valid),
    .q_sop   (out_sop),
    .any_vld (any_vld_s)
  );

  // Output sample counter; a held output during a stall is counted once, when the datapath advances.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      out_cnt_r <= {LW{1'b0}};
    end else if (out_valid & fft_en) begin
      if (out_sop) begin
        out_cnt_r <= LW'(1);
      end else if (out_cnt_r == CNT_MAX) begin
        out_cnt_r <= {LW{1'b0}};
      end else begin
        out_cnt_r <= out_cnt_r + LW'(1);
      end
    end
  end

  // Output bin is the bit-reversed sample count; a tagged sop is always bin 0.
  always_comb begin
    rev_s = {LW{1'b0}};
    for (int b = 0; b < LW; b++) begin
      rev_s[b] = out_cnt_r[LW-1-b];
    end
    if (out_sop) begin
      out_idx = {LW{1'b0}};
    end else begin
      out_idx = rev_s;
    end
  end

  assign out_eop = out_valid & (out_cnt_r == CNT_MAX);
  assign busy    = (state_r == ST_RUN) | (state_r == ST_FLUSH) | any_vld_s;
  assign sop_err = sop_err_r;

endmodule
